// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer in front of the 32-bit ALU: narrow ops in one pass, 64-bit ADD/SUB as two chained passes.
// Define ALU_SEQ_BYPASS_EN to allow a new request to be accepted in the same cycle a response is taken.
module alu_op_sequencer #(
  parameter logic [3:0] FLAG_RST = 4'b0000,
  parameter logic [3:0] OP_ADD   = 4'd4,
  parameter logic [3:0] OP_SUB   = 4'd7,
  parameter logic [3:0] OP_ADC   = 4'd8,
  parameter logic [3:0] OP_SBC   = 4'd9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [0:3]  req_op,
  input  logic        req_wide,
  input  logic        req_s,
  input  logic [0:31] req_a_lo,
  input  logic [0:31] req_b_lo,
  input  logic [0:31] req_a_hi,
  input  logic [0:31] req_b_hi,
  output logic [0:3]  alu_op,
  output logic [0:31] alu_a,
  output logic [0:31] alu_b,
  output logic        alu_cin,
  input  logic [0:31] alu_o,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:31] rsp_lo,
  output logic [0:31] rsp_hi,
  output logic        rsp_err,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_v
);

  typedef enum logic [1:0] {IDLE, EXEC_LO, EXEC_HI, RESP} state_t;

  state_t      state;
  logic        wide_q, err_q, sub_q, s_q, lo_z_q;
  logic [0:31] a_hi_q, b_hi_q;
  logic        accept, wide_ok;

`ifdef ALU_SEQ_BYPASS_EN
  assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
`else
  assign req_ready = (state == IDLE);
`endif

  assign accept  = req_valid && req_ready;
  assign wide_ok = req_wide && ((req_op == OP_ADD) || (req_op == OP_SUB));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wide_q    <= 1'b0;
      err_q     <= 1'b0;
      sub_q     <= 1'b0;
      s_q       <= 1'b0;
      lo_z_q    <= 1'b0;
      a_hi_q    <= '0;
      b_hi_q    <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_lo    <= '0;
      rsp_hi    <= '0;
      rsp_err   <= 1'b0;
      flag_n    <= FLAG_RST[3];
      flag_z    <= FLAG_RST[2];
      flag_c    <= FLAG_RST[1];
      flag_v    <= FLAG_RST[0];
    end else begin
      case (state)
        IDLE: begin
        end
        EXEC_LO: begin
          rsp_lo <= alu_o;
          if (wide_q) begin
            // Low-pass carry/borrow feeds the high pass directly.
            lo_z_q  <= alu_z;
            alu_a   <= a_hi_q;
            alu_b   <= b_hi_q;
            alu_op  <= sub_q ? OP_SBC : OP_ADC;
            alu_cin <= alu_cout;
            state   <= EXEC_HI;
          end else begin
            rsp_hi    <= '0;
            rsp_err   <= err_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
            if (s_q && !err_q) begin
              flag_n <= alu_n;
              flag_z <= alu_z;
              flag_c <= alu_cout;
              flag_v <= alu_v;
            end
          end
        end
        EXEC_HI: begin
          rsp_hi    <= alu_o;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
          if (s_q) begin
            flag_n <= alu_n;
            flag_z <= lo_z_q && alu_z;
            flag_c <= alu_cout;
            flag_v <= alu_v;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A new request overrides the RESP->IDLE return when bypass is enabled.
      if (accept) begin
        state   <= EXEC_LO;
        wide_q  <= wide_ok;
        err_q   <= req_wide && !wide_ok;
        sub_q   <= (req_op == OP_SUB);
        s_q     <= req_s;
        a_hi_q  <= req_a_hi;
        b_hi_q  <= req_b_hi;
        alu_a   <= req_a_lo;
        alu_b   <= req_b_lo;
        alu_op  <= req_op;
        alu_cin <= wide_ok ? 1'b0 : flag_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU and a 64-bit arithmetic reference model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wide, req_s;
  logic [0:3]  req_op;
  logic [0:31] req_a_lo, req_b_lo, req_a_hi, req_b_hi;
  logic [0:3]  alu_op;
  logic [0:31] alu_a, alu_b, alu_o;
  logic        alu_cin, alu_n, alu_z, alu_v, alu_cout;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [0:31] rsp_lo, rsp_hi;
  logic        flag_n, flag_z, flag_c, flag_v;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_wide(req_wide), .req_s(req_s),
    .req_a_lo(req_a_lo), .req_b_lo(req_b_lo), .req_a_hi(req_a_hi), .req_b_hi(req_b_hi),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_o(alu_o), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
    .rsp_err(rsp_err),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  // Behavioural ALU: returns {N,Z,C,V,result}; subtract carry is a borrow.
  function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    logic [32:0] t;
    logic [31:0] o;
    logic c, v;
    t = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: o = a | b;
      4'd1: o = a & b;
      4'd2: o = a ^ b;
      4'd3: o = ~a;
      4'd5: begin o = a << 1; c = a[31]; end
      4'd6: begin o = a >> 1; c = a[0]; end
      4'd4, 4'd8: begin
        t = {1'b0, a} + {1'b0, b} + {32'd0, (op == 4'd8) && cin};
        o = t[31:0]; c = t[32];
        v = (a[31] == b[31]) && (o[31] != a[31]);
      end
      4'd7, 4'd9: begin
        t = {1'b0, a} - {1'b0, b} - {32'd0, (op == 4'd9) && cin};
        o = t[31:0]; c = t[32];
        v = (a[31] != b[31]) && (o[31] != a[31]);
      end
      default: o = a;
    endcase
    return {o[31], (o == 32'd0), c, v, o};
  endfunction

  logic [35:0] alu_res;
  always_comb alu_res = alu_f(alu_op, alu_a, alu_b, alu_cin);
  assign {alu_n, alu_z, alu_cout, alu_v} = alu_res[35:32];
  assign alu_o = alu_res[31:0];

  typedef struct {
    logic [31:0] lo, hi, a_lo, a_hi;
    logic        err, wide, cin_lo, cin_hi;
    logic [3:0]  flags, op_lo, op_hi;
    int          acc;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mflags;
  int         n_checks = 0;
  int         n_fail = 0;
  int         rdy_mode = 1;
  bit         lat_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: rsp_ready = ($urandom_range(0, 3) != 0);
      1: rsp_ready = 1'b1;
      default: rsp_ready = 1'b0;
    endcase
  end

  task automatic issue(input logic [3:0] op, input logic wide, input logic s,
                       input logic [31:0] alo, input logic [31:0] blo,
                       input logic [31:0] ahi, input logic [31:0] bhi);
    exp_t        e;
    int          w;
    logic        ok_wide;
    logic [63:0] a64, b64;
    logic [64:0] r;
    logic [35:0] nr;
    logic [3:0]  nf;
    req_op = op; req_wide = wide; req_s = s;
    req_a_lo = alo; req_b_lo = blo; req_a_hi = ahi; req_b_hi = bhi;
    req_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    ok_wide  = wide && (op == 4'd4 || op == 4'd7);
    e.err    = wide && !ok_wide;
    e.wide   = ok_wide;
    e.acc    = cyc;
    e.a_lo   = alo;
    e.a_hi   = ahi;
    e.op_lo  = op;
    e.op_hi  = (op == 4'd7) ? 4'd9 : 4'd8;
    e.cin_lo = ok_wide ? 1'b0 : mflags[1];
    e.cin_hi = 1'b0;
    if (ok_wide) begin
      a64 = {ahi, alo};
      b64 = {bhi, blo};
      if (op == 4'd4) begin
        r = {1'b0, a64} + {1'b0, b64};
        nf = {r[63], (r[63:0] == 64'd0), r[64], (a64[63] == b64[63]) && (r[63] != a64[63])};
        e.cin_hi = ({1'b0, alo} + {1'b0, blo}) > 33'h0FFFFFFFF;
      end else begin
        r = {1'b0, a64} - {1'b0, b64};
        nf = {r[63], (r[63:0] == 64'd0), r[64], (a64[63] != b64[63]) && (r[63] != a64[63])};
        e.cin_hi = (alo < blo);
      end
      e.lo = r[31:0];
      e.hi = r[63:32];
    end else begin
      nr   = alu_f(op, alo, blo, mflags[1]);
      e.lo = nr[31:0];
      e.hi = 32'd0;
      nf   = nr[35:32];
    end
    if (s && !e.err) mflags = nf;
    e.flags = mflags;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() > 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    if (sb.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
    end
    #1;
  endtask

  // Monitor: checks ALU drive during execution and every presented response.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && cyc == sb[0].acc + 1) begin
        chk("exec_lo_a", alu_a, sb[0].a_lo);
        chk("exec_lo_op", alu_op, sb[0].op_lo);
        chk("exec_lo_cin", alu_cin, sb[0].cin_lo);
      end
      if (sb.size() > 0 && sb[0].wide && cyc == sb[0].acc + 2) begin
        chk("exec_hi_a", alu_a, sb[0].a_hi);
        chk("exec_hi_op", alu_op, sb[0].op_hi);
        chk("exec_hi_cin", alu_cin, sb[0].cin_hi);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          if (!lat_done) chk("latency", cyc - sb[0].acc, sb[0].wide ? 3 : 2);
          lat_done = 1;
          chk("rsp_lo", rsp_lo, sb[0].lo);
          chk("rsp_hi", rsp_hi, sb[0].hi);
          chk("rsp_err", rsp_err, sb[0].err);
          chk("flags", {flag_n, flag_z, flag_c, flag_v}, sb[0].flags);
`ifdef ALU_SEQ_BYPASS_EN
          chk("req_ready_resp", req_ready, rsp_ready);
`else
          chk("req_ready_resp", req_ready, 1'b0);
`endif
          if (rsp_ready) begin
            void'(sb.pop_front());
            lat_done = 0;
          end
        end
      end
    end
  end

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] op;
    logic       wd;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_wide = 1'b0; req_s = 1'b0;
    req_a_lo = '0; req_b_lo = '0; req_a_hi = '0; req_b_hi = '0; rsp_ready = 1'b0;
    mflags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", {rsp_hi, rsp_lo}, 64'd0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_flags", {flag_n, flag_z, flag_c, flag_v}, 4'b0000);
    chk("rst_alu", {alu_op, alu_a, alu_b, alu_cin}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(4'd4, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000000);
    issue(4'd7, 1'b1, 1'b1, 32'h0, 32'h1, 32'h0, 32'h0);
    issue(4'd4, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    issue(4'd8, 1'b0, 1'b0, 32'd5, 32'd3, 32'h0, 32'h0);
    issue(4'd1, 1'b1, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h12345678, 32'h9ABCDEF0);
    drain();

    rdy_mode = 2;
    issue(4'd2, 1'b0, 1'b1, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0, 32'h0);
    fork
      begin
        repeat (6) @(posedge clk);
        rdy_mode = 1;
      end
    join_none
    issue(4'd4, 1'b0, 1'b1, 32'd100, 32'd23, 32'h0, 32'h0);
    drain();

    issue(4'd4, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h7, 32'h8);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_flags", {flag_n, flag_z, flag_c, flag_v}, 4'b0000);
    chk("midrst_alu_op", alu_op, 4'd0);
    sb.delete();
    lat_done = 0;
    mflags = 4'b0000;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    issue(4'd7, 1'b0, 1'b1, 32'd3, 32'd9, 32'h0, 32'h0);
    drain();

    rdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      wd = ($urandom_range(0, 1) == 1);
      op = $urandom_range(0, 15);
      if (wd && $urandom_range(0, 3) != 0) op = ($urandom_range(0, 1) == 1) ? 4'd4 : 4'd7;
      issue(op, wd, $urandom_range(0, 1) == 1, rnd_word(), rnd_word(), rnd_word(), rnd_word());
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
